// File: rtl/imemfifo_if.sv
// Push/pop handshake and single-port RAM bundle for imemfifo.
// The slave modport is the FIFO controller side.
interface imemfifo_if #(
   parameter int ADDRBIT = 11,
   parameter int WIDTH   = 32
);
   logic               wr_vld;
   logic               wr_rdy;
   logic [WIDTH-1:0]   wr_dat;
   logic               rd_vld;
   logic               rd_rdy;
   logic [WIDTH-1:0]   rd_dat;
   logic [ADDRBIT-1:0] mem_a;
   logic               mem_we;
   logic               mem_re;
   logic [WIDTH-1:0]   mem_di;
   logic [WIDTH-1:0]   mem_do;
   logic [ADDRBIT:0]   cnt;

   modport slave (
      input  wr_vld, wr_dat, rd_rdy, mem_do,
      output wr_rdy, rd_vld, rd_dat, mem_a, mem_we, mem_re, mem_di, cnt
   );

   modport master (
      output wr_vld, wr_dat, rd_rdy, mem_do,
      input  wr_rdy, rd_vld, rd_dat, mem_a, mem_we, mem_re, mem_di, cnt
   );
endinterface

// File: rtl/imemfifo.sv
// Streaming FIFO controller around a single-port RAM with fixed LAT-cycle read latency.
// Reads are credit-limited so the small output buffer can always absorb in-flight data.
module imemfifo #(
   parameter int ADDRBIT = 11,
   parameter int DEPTH   = 1536,
   parameter int WIDTH   = 32,
   parameter int LAT     = 3
) (
   input  logic      clk,
   input  logic      rst,
   imemfifo_if.slave bus
);
   localparam int BW = $clog2(LAT + 2);
   localparam int IW = (LAT > 0) ? $clog2(LAT + 1) : 1;
   localparam logic [ADDRBIT:0]   DEPTH_C  = (ADDRBIT + 1)'(DEPTH);
   localparam logic [ADDRBIT-1:0] PTR_LAST = ADDRBIT'(DEPTH - 1);
   localparam logic [BW:0]        OCC_MAX  = (BW + 1)'(LAT + 1);
   localparam logic [IW-1:0]      BUF_LAST = IW'(LAT);

   logic [ADDRBIT-1:0] wptr, rptr;
   logic [ADDRBIT:0]   mcnt, cnt_q;
   logic [LAT-1:0]     infl;
   logic [WIDTH-1:0]   obuf [LAT+1];
   logic [IW-1:0]      bhead, btail;
   logic [BW-1:0]      bcnt;
   logic               prio_rd;

   logic [BW:0] occ;
   logic        rd_want, rd_issue, wr_ok, wr_acc, capture, pop;

   function automatic logic [BW:0] popcnt(input logic [LAT-1:0] v);
      logic [BW:0] s;
      s = '0;
      for (int i = 0; i < LAT; i++) s = s + (BW + 1)'(v[i]);
      return s;
   endfunction

   always_comb begin
      occ      = {1'b0, bcnt} + popcnt(infl);
      rd_want  = (mcnt != '0) && (occ < OCC_MAX);
      wr_ok    = (mcnt != DEPTH_C) && !(rd_want && prio_rd);
      wr_acc   = bus.wr_vld && wr_ok;
      rd_issue = rd_want && (prio_rd || !bus.wr_vld);
      capture  = infl[LAT-1];
      pop      = (bcnt != '0) && bus.rd_rdy;
   end

   assign bus.wr_rdy = wr_ok;
   assign bus.mem_we = wr_acc;
   assign bus.mem_re = rd_issue;
   assign bus.mem_a  = wr_acc ? wptr : rptr;
   assign bus.mem_di = bus.wr_dat;
   assign bus.rd_vld = (bcnt != '0);
   assign bus.rd_dat = obuf[bhead];
   assign bus.cnt    = cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr    <= '0;
         rptr    <= '0;
         mcnt    <= '0;
         infl    <= '0;
         bhead   <= '0;
         btail   <= '0;
         bcnt    <= '0;
         prio_rd <= 1'b0;
         cnt_q   <= '0;
      end else begin
         if (wr_acc) begin
            wptr    <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
            mcnt    <= mcnt + 1'b1;
            prio_rd <= 1'b1;
         end else if (rd_issue) begin
            rptr    <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
            mcnt    <= mcnt - 1'b1;
            prio_rd <= 1'b0;
         end

         infl <= (infl << 1) | LAT'(rd_issue);

         if (capture) btail <= (btail == BUF_LAST) ? '0 : btail + 1'b1;
         if (pop)     bhead <= (bhead == BUF_LAST) ? '0 : bhead + 1'b1;

         case ({capture, pop})
            2'b10:   bcnt <= bcnt + 1'b1;
            2'b01:   bcnt <= bcnt - 1'b1;
            default: bcnt <= bcnt;
         endcase

         case ({wr_acc, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Data registers are not reset; rd_dat only has meaning while rd_vld is high.
   always_ff @(posedge clk) begin
      if (capture) obuf[btail] <= bus.mem_do;
   end
endmodule

// File: doc/imemfifo.md
# imemfifo

Single-clock FIFO controller that sits directly upstream of the wrapped single-port RAM (`imemspx`) and turns it into a streaming buffer with valid/ready push and pop ports. It arbitrates the one RAM port between writes and reads and tracks the RAM's fixed 3-cycle read latency. A small register-based output buffer absorbs in-flight read data so that pop backpressure never loses a word.

## Interface
- `ADDRBIT`, 11: RAM address width.
- `DEPTH`, 1536: RAM words. Need not be a power of 2. Requires DEPTH+LAT+1 < 2^(ADDRBIT+1).
- `WIDTH`, 32: data width.
- `LAT`, 3: cycles from `mem_a`/`mem_re` to valid `mem_do`. Fixed by the RAM wrapper.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `wr_vld`  in  1  push data valid.
- `wr_rdy`  out  1  push accepted when `wr_vld & wr_rdy`.
- `wr_dat`  in  WIDTH  push data.
- `rd_vld`  out  1  pop data valid.
- `rd_rdy`  in  1  pop accepted when `rd_vld & rd_rdy`.
- `rd_dat`  out  WIDTH  pop data, head of the output buffer.
- `mem_a`  out  ADDRBIT  RAM address.
- `mem_we`  out  1  RAM write enable.
- `mem_re`  out  1  RAM read enable.
- `mem_di`  out  WIDTH  RAM write data; equals `wr_dat`.
- `mem_do`  in  WIDTH  RAM read data.
- `cnt`  out  ADDRBIT+1  words accepted but not yet popped (RAM, in flight, and buffer).

## Operation
**State**
- `wptr`, `rptr`: wrap from DEPTH-1 to 0.
- `mcnt`: words held in RAM, 0..DEPTH.
- `infl`: LAT-bit shift register marking reads in flight.
- `obuf`: LAT+1-entry register FIFO with occupancy `bcnt`.
- `prio_rd`: arbitration flag.

**Read request**
- `rd_want = (mcnt != 0) & (bcnt + popcount(infl) < LAT+1)`.
- This credit rule guarantees that `obuf` never overflows.

**Arbitration** (one RAM access per cycle)
- `rd_issue = rd_want & (prio_rd | ~wr_vld)`.
- `wr_rdy = (mcnt != DEPTH) & ~(rd_want & prio_rd)`.
- `wr_rdy` does not depend on `wr_vld`.
- `prio_rd` is set by an accepted write and cleared by a read issue. When both sides are busy, accesses alternate.

**RAM drive**
- Write cycle: `mem_we=1`, `mem_a=wptr`; then `wptr++` and `mcnt++`.
- Read issue: `mem_re=1`, `mem_a=rptr`; then `rptr++`, `mcnt--`, and `infl[0]` is set.
- Idle: `mem_we=mem_re=0`, `mem_a=rptr`.
- A write and a read issue are never asserted together.

**Capture and pop**
- When `infl[LAT-1]` is set, `mem_do` is pushed into `obuf`.
- `rd_vld = (bcnt != 0)`; `rd_dat` is the head of `obuf`.
- A simultaneous capture and pop keeps `bcnt` unchanged.
- `cnt` increments on an accepted push and decrements on an accepted pop. Both in the same cycle leaves it unchanged.

**Ordering and RAM contents**
- Ordering is strictly FIFO. Read-after-write through the RAM is safe because the wrapper pipeline is in order.
- RAM contents are never initialised or cleared.

**Reset** (asynchronous, may hit mid-operation)
- Clears the pointers, `mcnt`, `infl`, `bcnt` and `prio_rd`.
- In-flight reads and buffered words are discarded.
- Outputs after reset: `wr_rdy=1`, `rd_vld=0`, `mem_we=0`, `mem_re=0`, `mem_a=0`, `cnt=0`.
- `rd_dat` is undefined but stable.

## Timing
- `mem_we`, `mem_re`, `mem_a`, `mem_di` and `wr_rdy` are combinational from registered state and `wr_vld`. The RAM wrapper registers its inputs, so no further path constraint applies.
- A read issued in cycle c presents `mem_do` in cycle c+LAT; it is captured at the end of that cycle.
- First-word latency on an empty FIFO, for a push accepted in cycle 0:
  - read issued in cycle 1;
  - `rd_vld` high in cycle LAT+2 = 5.
- Throughput:
  - push-only: 1 word/cycle until full;
  - pop-only: 1 word/cycle sustained (LAT+1 credits);
  - both busy: 0.5 word/cycle each.
- Full: `wr_rdy=0` while `mcnt==DEPTH`. The maximum value of `cnt` is DEPTH+LAT+1 = 1540.

## Test plan
- **Single word.** Reset, then push 32'hA5A5_0001 in cycle 0 with `rd_rdy=1`. Required: `mem_re` in cycle 1, `rd_vld` in cycle 5 with `rd_dat`=32'hA5A5_0001, and `cnt` goes 0→1→0.
- **Fill and drain.** Push an incrementing pattern with `rd_rdy=0`. Required: 1540 words accepted, then `wr_rdy=0` and `cnt`=1540. Then hold `rd_rdy=1`: all 1540 words pop in order, at 1 word/cycle once streaming.
- **Concurrent traffic.** Hold `wr_vld` and `rd_rdy` continuously high with 200 words. Required: `mem_we` and `mem_re` alternate, no cycle has both high, and order is preserved.
- **Pointer wrap.** Stream 4000 words through with random gaps. Required: pointers wrap 1535→0 with no lost or duplicated data.
- **Random backpressure.** Toggle `rd_rdy` randomly at 30% duty. Required: no overflow of `obuf`, `rd_dat` stable while `rd_vld & ~rd_rdy`, and a scoreboard match.
- **Reset mid-stream.** Assert `rst` for one cycle with 3 reads in flight and 2 words buffered. Required: `rd_vld=0`, `cnt=0`, `wr_rdy=1` immediately. A subsequent push of 32'h0000_00FF pops as the first word.
